// File: rtl/pwm_compare_deadtime_pkg.sv
// Shared types for the PWM compare / dead-time channel: carrier modes, enable,
// shadow load points and the dead-time FSM encoding.
package pwm_compare_deadtime_pkg;

  localparam int PWMCOUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    NO_COUNT,
    COUNT_UP,
    COUNT_DOWN,
    COUNT_UPDOWN
  } _count_mode;

  typedef enum logic {
    PWM_OFF,
    PWM_ON
  } _pwm_onoff;

  typedef enum logic [1:0] {
    LOAD_ZERO,
    LOAD_PERIOD,
    LOAD_BOTH,
    LOAD_IMMEDIATE
  } _load_mode;

  typedef enum logic [1:0] {
    S_OFF,
    S_H_ON,
    S_L_ON,
    S_DT
  } _state_dt;

  // A leg with no running carrier or an empty period has nothing to compare against.
  function automatic logic pwm_disabled(input _pwm_onoff onoff, input _count_mode mode,
                                        input logic period_zero);
    return (onoff == PWM_OFF) || (mode == NO_COUNT) || period_zero;
  endfunction

endpackage

// File: rtl/pwm_shadow_reg.sv
// Shadow register with carrier zero/peak event detection; the active value is
// refreshed at the chosen carrier event, or every cycle in immediate mode.
module pwm_shadow_reg
  import pwm_compare_deadtime_pkg::*;
#(
  parameter int W = PWMCOUNT_WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic [W-1:0] cnt_i,
  input  logic [W-1:0] top_i,
  input  logic [W-1:0] value_i,
  input  _load_mode load_mode_i,
  input  logic      disabled_i,
  output logic [W-1:0] value_o,
  output logic      load_evt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] value_q, value_d;
  logic         evt_q, evt_d;
  logic         zero_evt, top_evt;

  // Edge-qualified so a carrier dwelling at 0 or at the top fires only once.
  assign zero_evt = (cnt_i == '0) && (cnt_q != '0);
  assign top_evt  = (cnt_i == top_i) && (cnt_q != top_i);

  always_comb begin
    value_d = value_q;
    evt_d   = 1'b0;
    if (disabled_i) begin
      value_d = value_i;
    end else begin
      unique case (load_mode_i)
        LOAD_ZERO: begin
          if (zero_evt) begin
            value_d = value_i;
            evt_d   = 1'b1;
          end
        end
        LOAD_PERIOD: begin
          if (top_evt) begin
            value_d = value_i;
            evt_d   = 1'b1;
          end
        end
        LOAD_BOTH: begin
          if (zero_evt || top_evt) begin
            value_d = value_i;
            evt_d   = 1'b1;
          end
        end
        LOAD_IMMEDIATE: begin
          value_d = value_i;
          evt_d   = (value_i != value_q);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      value_q <= '0;
      evt_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_i;
      value_q <= value_d;
      evt_q   <= evt_d;
    end
  end

  assign value_o    = value_q;
  assign load_evt_o = evt_q;

endmodule

// File: rtl/pwm_compare_deadtime.sv
// One PWM leg: carrier vs shadowed compare, then a complementary high/low gate
// pair separated by a programmable both-off dead time.
module pwm_compare_deadtime
  import pwm_compare_deadtime_pkg::*;
#(
  parameter int CNT_W = PWMCOUNT_WIDTH,
  parameter int DT_W  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] carrier,
  input  logic [CNT_W-1:0] period,
  input  _count_mode       count_mode,
  input  _pwm_onoff        pwm_onoff,
  input  logic [CNT_W-1:0] compare,
  input  _load_mode        load_mode,
  input  logic [DT_W-1:0]  deadtime,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic [CNT_W-1:0] cmp_active,
  output logic             load_evt
);

  logic            disabled;
  logic            raw_q, raw_d1_q;
  logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
  _state_dt        state_q, state_d, side_sel;
  logic            pwm_h_q, pwm_h_d, pwm_l_q, pwm_l_d;
  logic            dt_zero;

  assign disabled = pwm_disabled(pwm_onoff, count_mode, period == '0);

  pwm_shadow_reg #(.W(CNT_W)) u_cmp_shadow (
    .clk         (clk),
    .reset       (reset),
    .cnt_i       (carrier),
    .top_i       (period),
    .value_i     (compare),
    .load_mode_i (load_mode),
    .disabled_i  (disabled),
    .value_o     (cmp_active),
    .load_evt_o  (load_evt)
  );

  assign dt_zero  = (deadtime == '0);
  assign side_sel = raw_q ? S_H_ON : S_L_ON;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_q    <= 1'b0;
      raw_d1_q <= 1'b0;
      state_q  <= S_OFF;
      dt_cnt_q <= '0;
      pwm_h_q  <= 1'b0;
      pwm_l_q  <= 1'b0;
    end else begin
      raw_q    <= (carrier < cmp_active);
      raw_d1_q <= raw_q;
      state_q  <= state_d;
      dt_cnt_q <= dt_cnt_d;
      pwm_h_q  <= pwm_h_d;
      pwm_l_q  <= pwm_l_d;
    end
  end

  // The counter runs deadtime..1, so S_DT lasts exactly deadtime cycles; a zero
  // dead time bypasses S_DT and swaps sides on the same edge.
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    if (disabled) begin
      state_d  = S_OFF;
      dt_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_OFF: begin
          if (dt_zero) begin
            state_d = side_sel;
          end else begin
            state_d  = S_DT;
            dt_cnt_d = deadtime;
          end
        end
        S_H_ON: begin
          if (!raw_q) begin
            if (dt_zero) begin
              state_d = S_L_ON;
            end else begin
              state_d  = S_DT;
              dt_cnt_d = deadtime;
            end
          end
        end
        S_L_ON: begin
          if (raw_q) begin
            if (dt_zero) begin
              state_d = S_H_ON;
            end else begin
              state_d  = S_DT;
              dt_cnt_d = deadtime;
            end
          end
        end
        S_DT: begin
          if (raw_q != raw_d1_q) begin
            if (dt_zero) begin
              state_d  = side_sel;
              dt_cnt_d = '0;
            end else begin
              dt_cnt_d = deadtime;
            end
          end else if (dt_cnt_q <= DT_W'(1)) begin
            state_d  = side_sel;
            dt_cnt_d = '0;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_W'(1);
          end
        end
      endcase
    end
  end

  // Gates are registered from the next state so they change on the same edge.
  always_comb begin
    pwm_h_d = (state_d == S_H_ON);
    pwm_l_d = (state_d == S_L_ON);
  end

  assign pwm_h = pwm_h_q;
  assign pwm_l = pwm_l_q;

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// Directed and randomized checks of one PWM leg against a window-based model:
// a side is on only when enable and the raw compare have held steady long enough.
module tb_pwm_compare_deadtime;
  import pwm_compare_deadtime_pkg::*;

  localparam int MAXK = 20000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] carrier, period, compare;
  _count_mode  count_mode;
  _pwm_onoff   pwm_onoff;
  _load_mode   load_mode;
  logic [9:0]  deadtime;
  logic        pwm_h, pwm_l, load_evt;
  logic [15:0] cmp_active;

  always #5 clk = ~clk;

  pwm_compare_deadtime #(.CNT_W(16), .DT_W(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .carrier    (carrier),
    .period     (period),
    .count_mode (count_mode),
    .pwm_onoff  (pwm_onoff),
    .compare    (compare),
    .load_mode  (load_mode),
    .deadtime   (deadtime),
    .pwm_h      (pwm_h),
    .pwm_l      (pwm_l),
    .cmp_active (cmp_active),
    .load_evt   (load_evt)
  );

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;
  bit r_hist[MAXK];
  bit dis_hist[MAXK];
  logic [15:0] m_cmp, m_cprev;
  logic m_evt, exp_h, exp_l;
  int c = 0;
  bit up = 1'b1;
  int cnt_h, cnt_l, cnt_both, cnt_evt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_async_reset();
    m_cmp = '0; m_cprev = '0; m_evt = 1'b0; exp_h = 1'b0; exp_l = 1'b0;
  endtask

  // Called at each active edge with the inputs the DUT sampled there.
  task automatic model_edge();
    bit dis, rk, zero_e, peak_e, on;
    int d;
    if (k >= MAXK) begin
      $display("FAIL model_history: step %0d exceeds %0d", k, MAXK);
      $fatal(1);
    end
    if (reset) begin
      model_async_reset();
      r_hist[k] = 1'b0;
      dis_hist[k] = 1'b1;
      k++;
      return;
    end
    d = int'(deadtime);
    dis = (pwm_onoff == PWM_OFF) || (count_mode == NO_COUNT) || (period == 0);
    rk = (carrier < m_cmp);
    zero_e = (carrier == 0) && (m_cprev != 0);
    peak_e = (carrier == period) && (m_cprev != period);
    m_evt = 1'b0;
    if (dis) m_cmp = compare;
    else if (load_mode == LOAD_IMMEDIATE) begin
      m_evt = (compare != m_cmp);
      m_cmp = compare;
    end else if ((load_mode == LOAD_ZERO && zero_e) || (load_mode == LOAD_PERIOD && peak_e) ||
                 (load_mode == LOAD_BOTH && (zero_e || peak_e))) begin
      m_evt = 1'b1;
      m_cmp = compare;
    end
    m_cprev = carrier;
    r_hist[k] = rk;
    dis_hist[k] = dis;
    on = (k > 0);
    for (int j = k - d; j <= k; j++) if (j < 0 || dis_hist[j]) on = 1'b0;
    if (on) for (int j = k - 1 - d; j <= k - 1; j++) if (j < 0 || r_hist[j] != r_hist[k-1]) on = 1'b0;
    exp_h = on && r_hist[k-1];
    exp_l = on && !r_hist[k-1];
    k++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("pwm_h", pwm_h, exp_h);
    chk("pwm_l", pwm_l, exp_l);
    chk("cmp_active", cmp_active, m_cmp);
    chk("load_evt", load_evt, m_evt);
    chk("exclusive", pwm_h & pwm_l, 1'b0);
    cnt_h += pwm_h;
    cnt_l += pwm_l;
    cnt_both += (!pwm_h && !pwm_l);
    cnt_evt += load_evt;
  endtask

  task automatic clr();
    cnt_h = 0; cnt_l = 0; cnt_both = 0; cnt_evt = 0;
  endtask

  // Behaves like the upstream carrier generator for the current mode.
  task automatic adv();
    case (count_mode)
      COUNT_UP:   c = (c >= int'(period)) ? 0 : c + 1;
      COUNT_DOWN: c = (c == 0 || c > int'(period)) ? int'(period) : c - 1;
      COUNT_UPDOWN: begin
        if (up) begin
          if (c >= int'(period)) begin up = 1'b0; c = c - 1; end
          else c = c + 1;
        end else begin
          if (c == 0) begin up = 1'b1; c = 1; end
          else c = c - 1;
        end
      end
      default: ;
    endcase
    carrier = 16'(c);
  endtask

  task automatic run(input int n);
    repeat (n) begin adv(); step(); end
  endtask

  task automatic go_off();
    pwm_onoff = PWM_OFF;
    step(); step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    reset = 1'b1; carrier = 0; period = 100; compare = 40; count_mode = COUNT_UP;
    pwm_onoff = PWM_OFF; load_mode = LOAD_IMMEDIATE; deadtime = 5;
    #1;
    model_async_reset();
    chk("reset_h", pwm_h, 1'b0);
    chk("reset_l", pwm_l, 1'b0);
    chk("reset_cmp", cmp_active, 16'd0);
    chk("reset_evt", load_evt, 1'b0);
    repeat (3) step();
    reset = 1'b0;

    // basic up-count, immediate load
    pwm_onoff = PWM_ON; c = 0; carrier = 0;
    run(250);
    clr(); run(101);
    chk("basic_h", cnt_h, 35);
    chk("basic_l", cnt_l, 56);
    chk("basic_gap", cnt_both, 10);

    // shadow load at carrier zero
    load_mode = LOAD_ZERO;
    g = 0;
    while (c != 19 && g < 200) begin adv(); step(); g++; end
    compare = 70;
    clr();
    adv(); step();
    g = 0;
    while (c != 0 && g < 200) begin adv(); step(); g++; end
    chk("shadow_evt_at_zero", cnt_evt, 1);
    run(20);
    clr(); run(101);
    chk("shadow_h", cnt_h, 65);
    chk("shadow_evt_per", cnt_evt, 1);

    // up-down, load at both ends
    go_off();
    count_mode = COUNT_UPDOWN; period = 50; compare = 25; deadtime = 3;
    load_mode = LOAD_BOTH; c = 0; up = 1'b1; carrier = 0;
    step(); step();
    pwm_onoff = PWM_ON;
    run(200);
    clr(); run(100);
    chk("updown_h", cnt_h, 46);
    chk("updown_l", cnt_l, 48);
    chk("updown_evt", cnt_evt, 2);
    g = 0;
    while (c != 10 && g < 200) begin adv(); step(); g++; end
    clr(); carrier = 0;
    repeat (5) step();
    chk("dwell_zero_evt", cnt_evt, 1);
    clr(); carrier = 50;
    repeat (5) step();
    chk("dwell_peak_evt", cnt_evt, 1);

    // compare = 0: low side only
    go_off();
    count_mode = COUNT_UP; period = 100; compare = 0; deadtime = 3;
    load_mode = LOAD_IMMEDIATE; c = 0; up = 1'b1; carrier = 0;
    step(); step();
    pwm_onoff = PWM_ON;
    clr(); run(150);
    chk("cmp0_l", cnt_l, 147);
    chk("cmp0_h", cnt_h, 0);

    // compare above period: high side only
    go_off();
    period = 50; compare = 60; c = 0; carrier = 0;
    step(); step();
    pwm_onoff = PWM_ON;
    clr(); run(150);
    chk("cmpbig_h", cnt_h, 147);
    chk("cmpbig_l", cnt_l, 0);

    // zero dead time
    go_off();
    period = 100; compare = 40; deadtime = 0; c = 0; carrier = 0;
    step(); step();
    pwm_onoff = PWM_ON;
    run(150);
    clr(); run(101);
    chk("dt0_gap", cnt_both, 0);
    chk("dt0_h", cnt_h, 40);
    chk("dt0_l", cnt_l, 61);

    // raw toggles back inside the dead time
    go_off();
    deadtime = 10; compare = 50; carrier = 10;
    step(); step();
    pwm_onoff = PWM_ON;
    repeat (30) step();
    chk("glitch_pre_h", pwm_h, 1'b1);
    clr(); carrier = 60;
    repeat (4) step();
    carrier = 10;
    g = 0;
    while (pwm_h !== 1'b1 && g < 40) begin step(); g++; end
    chk("glitch_gap", cnt_both, 14);
    chk("glitch_side", pwm_h, 1'b1);

    // disable, re-enable, async reset
    deadtime = 5; compare = 40;
    repeat (10) step();
    pwm_onoff = PWM_OFF;
    step();
    chk("off_h", pwm_h, 1'b0);
    compare = 77;
    step();
    chk("off_track", cmp_active, 16'd77);
    compare = 40;
    step(); step();
    pwm_onoff = PWM_ON;
    clr(); g = 0;
    while (pwm_h !== 1'b1 && pwm_l !== 1'b1 && g < 30) begin step(); g++; end
    chk("on_gap", cnt_both, 5);
    chk("on_side", pwm_h, 1'b1);
    #3 reset = 1'b1;
    #1 model_async_reset();
    chk("async_h", pwm_h, 1'b0);
    chk("async_cmp", cmp_active, 16'd0);
    step(); step();
    reset = 1'b0;
    step(); step();
    #3 reset = 1'b1;
    #1 model_async_reset();
    chk("async_dt_cmp", cmp_active, 16'd0);
    chk("async_dt_l", pwm_l, 1'b0);
    repeat (3) step();
    reset = 1'b0;
    repeat (30) step();

    // randomized segments
    for (int s = 0; s < 8; s++) begin
      pwm_onoff = PWM_OFF;
      step();
      count_mode = _count_mode'($urandom_range(3, 1));
      period = (s == 3) ? 16'd0 : 16'($urandom_range(80, 1));
      compare = 16'($urandom_range(int'(period) + 10, 0));
      load_mode = _load_mode'($urandom_range(3, 0));
      deadtime = 10'($urandom_range(8, 0));
      c = 0; up = 1'b1; carrier = 0;
      step(); step();
      pwm_onoff = PWM_ON;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(15, 0) == 0) compare = 16'($urandom_range(int'(period) + 10, 0));
        if ($urandom_range(63, 0) == 0) pwm_onoff = (pwm_onoff == PWM_ON) ? PWM_OFF : PWM_ON;
        if (pwm_onoff == PWM_OFF && $urandom_range(3, 0) == 0) deadtime = 10'($urandom_range(8, 0));
        adv(); step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
